// File: rtl/add_f_pkg.sv
// Shared binary32 float definitions: field widths, special encodings, unpack helper.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package add_f_pkg;

   localparam int WORD_W  = 32;
   localparam int EXP_W   = 8;
   localparam int FRAC_W  = 23;
   localparam int BIAS    = 127;
   // All-ones exponent field; any result exponent at or above this overflows.
   localparam int EXP_MAX = 2 * BIAS + 1;

   localparam logic [WORD_W-1:0] QNAN    = 32'h7FC0_0000;
   localparam logic [WORD_W-1:0] POS_INF = 32'h7F80_0000;
   localparam logic [WORD_W-1:0] NEG_INF = 32'hFF80_0000;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W:0]   mant;   // hidden bit included; zero when exp field is 0
      logic              zero;   // exp field 0: true zero or flushed subnormal
      logic              inf;
      logic              nan;
   } fp_t;

   function automatic fp_t fp_unpack(input logic [WORD_W-1:0] x);
      fp_t u;
      u.sign = x[WORD_W-1];
      u.exp  = x[FRAC_W +: EXP_W];
      u.zero = (u.exp == '0);
      u.inf  = (&u.exp) && (x[FRAC_W-1:0] == '0);
      u.nan  = (&u.exp) && (|x[FRAC_W-1:0]);
      u.mant = u.zero ? '0 : {1'b1, x[FRAC_W-1:0]};
      return u;
   endfunction

endpackage

// File: rtl/add_f_if.sv
// Operand/result bundle for the float adder: in_valid/a/b towards the adder, out_valid/s back.
// Latency: n/a (wires only).
// Backpressure: none; the adder accepts an operand pair every cycle.
interface add_f_if;
   import add_f_pkg::*;

   logic              in_valid;
   logic [WORD_W-1:0] a;
   logic [WORD_W-1:0] b;
   logic              out_valid;
   logic [WORD_W-1:0] s;

   modport master (output in_valid, a, b, input  out_valid, s);
   modport slave  (input  in_valid, a, b, output out_valid, s);
endinterface

// File: rtl/add_f_lzc28.sv
// Leading-zero counter over a 28-bit word (normalize shift amount for float units).
// Latency: combinational.  Ports: data (28b in), cnt (5b out, 28 when data is all zero).
// Backpressure: n/a.
module lzc28 (
   input  logic [27:0] data,
   output logic [4:0]  cnt
);

   // Scan upwards so the highest set bit is the last to write cnt.
   always_comb begin
      cnt = 5'd28;
      for (int i = 0; i < 28; i++) begin
         if (data[i]) cnt = 5'(27 - i);
      end
   end

endmodule

// File: rtl/add_f.sv
// binary32 adder, round-to-nearest-even, subnormals flushed to zero on input and output.
// Latency: 1 cycle (full datapath combinational into the s/out_valid register).
// Backpressure: none; one operation per cycle.  Ports: clk, rst (sync, high), bus (slave).
module add_f
   import add_f_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   add_f_if.slave bus
);

   fp_t               ua, ub;
   logic [EXP_W-1:0]  aexp, bexp;
   logic              a_ge_b;
   logic              l_sign, s_sign;
   logic [EXP_W-1:0]  l_exp, s_exp, ediff;
   logic [FRAC_W:0]   l_mant, s_mant;
   logic [4:0]        shamt;
   logic [49:0]       sh;
   logic [26:0]       lop, sop;
   logic [27:0]       sum, smant;
   logic [4:0]        lz;
   logic signed [9:0] sexp, rexp;
   logic [23:0]       mant;
   logic              g, r, st, rnd_up;
   logic [24:0]       mant_r;
   logic [22:0]       frac_out;
   logic [WORD_W-1:0] res;

   lzc28 u_lzc (.data(sum), .cnt(lz));

   always_comb begin
      ua     = fp_unpack(bus.a);
      ub     = fp_unpack(bus.b);
      aexp   = ua.exp;
      bexp   = ub.exp;

      // Magnitude order follows directly from the {exp, frac} bit pattern.
      a_ge_b = (bus.a[30:0] >= bus.b[30:0]);
      l_sign = a_ge_b ? ua.sign : ub.sign;
      l_exp  = a_ge_b ? ua.exp  : ub.exp;
      l_mant = a_ge_b ? ua.mant : ub.mant;
      s_sign = a_ge_b ? ub.sign : ua.sign;
      s_exp  = a_ge_b ? ub.exp  : ua.exp;
      s_mant = a_ge_b ? ub.mant : ua.mant;

      // Align: beyond 26 places the smaller operand is pure sticky either way.
      ediff  = l_exp - s_exp;
      shamt  = (ediff > 8'd26) ? 5'd26 : ediff[4:0];
      sh     = {s_mant, 26'b0} >> shamt;
      lop    = {l_mant, 3'b000};
      sop    = {sh[49:24], |sh[23:0]};   // {mant, guard, round, sticky}

      sum    = (l_sign == s_sign) ? ({1'b0, lop} + {1'b0, sop})
                                  : ({1'b0, lop} - {1'b0, sop});

      // Counting zeros over 28 bits folds the carry-out case in: lz=0 means
      // a right shift by one relative to the 27-bit frame, hence the +1.
      smant  = sum << lz;
      sexp   = $signed({2'b00, l_exp}) + 10'sd1 - $signed({5'b00000, lz});

      mant   = smant[27:4];
      g      = smant[3];
      r      = smant[2];
      st     = |smant[1:0];
      rnd_up = g & (r | st | mant[0]);
      mant_r = {1'b0, mant} + {24'b0, rnd_up};
      rexp   = mant_r[24] ? (sexp + 10'sd1) : sexp;
      frac_out = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

      res = '0;
      if (ua.nan || ub.nan) begin
         res = QNAN;
      end else if (ua.inf && ub.inf) begin
         res = (ua.sign != ub.sign) ? QNAN : bus.a;
      end else if (ua.inf) begin
         res = bus.a;
      end else if (ub.inf) begin
         res = bus.b;
      end else if (ua.zero && ub.zero) begin
         res = {ua.sign & ub.sign, 31'b0};
      end else if (ua.zero) begin
         res = bus.b;
      end else if (ub.zero) begin
         res = bus.a;
      end else if (sum == '0) begin
         res = '0;                                   // exact cancellation is +0
      end else if (rexp >= $signed(10'(EXP_MAX))) begin
         res = l_sign ? NEG_INF : POS_INF;
      end else if (rexp <= 10'sd0) begin
         res = {l_sign, 31'b0};
      end else begin
         res = {l_sign, rexp[7:0], frac_out};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.s         <= '0;
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) bus.s <= res;
      end
   end

endmodule

// File: tb/tb_add_f.sv
module tb_add_f;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [31:0] last_s;

   always #5 clk = ~clk;

   add_f_if bus ();

   add_f dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] s;
   } vec_t;

   vec_t vecs[22];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", nm, got, want);
      end
   endtask

   // Drive one cycle, then check out_valid and s 1 time unit after the edge.
   task automatic step(input logic v, input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic [31:0] want, input string tag);
      bus.in_valid = v;
      bus.a        = ta;
      bus.b        = tb_v;
      @(posedge clk);
      #1;
      chk({tag, " out_valid"}, {31'b0, bus.out_valid}, {31'b0, v});
      chk({tag, " s"}, bus.s, want);
      if (v) last_s = want;
   endtask

   // ---------------- reference model: exact real arithmetic ----------------
   function automatic real f2r(input logic [31:0] x);
      int e;
      if (x[30:23] == 8'd0) return 0.0;
      e = int'(x[30:23]) - 127 + 1023;
      return $bitstoreal({x[31], 11'(e), x[22:0], 29'b0});
   endfunction

   function automatic logic [31:0] r2f(input real rv);
      logic [63:0] d;
      logic [52:0] m;
      logic [24:0] mm;
      logic        up;
      int          e;
      d  = $realtobits(rv);
      e  = int'(d[62:52]) - 1023 + 127;
      m  = {1'b1, d[51:0]};
      up = m[28] && ((|m[27:0]) || m[29]);
      mm = {1'b0, m[52:29]} + {24'b0, up};
      if (mm[24]) begin
         e++;
         mm = mm >> 1;
      end
      if (e >= 255) return d[63] ? 32'hFF800000 : 32'h7F800000;
      if (e <= 0)   return {d[63], 31'b0};
      return {d[63], 8'(e), mm[22:0]};
   endfunction

   function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
      bit  xn, yn, xi, yi;
      real sum;
      xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
      yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
      xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
      yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
      if (xn || yn) return 32'h7FC00000;
      if (xi && yi) return (x[31] != y[31]) ? 32'h7FC00000 : x;
      if (xi) return x;
      if (yi) return y;
      if (x[30:23] == 0 && y[30:23] == 0) return {x[31] & y[31], 31'b0};
      sum = f2r(x) + f2r(y);
      if (sum == 0.0) return 32'h0;
      return r2f(sum);
   endfunction

   function automatic logic [31:0] rnd_operand(input logic [31:0] other);
      logic [31:0] v;
      int e;
      v = $urandom;
      case ($urandom_range(0, 9))
         0: ;
         1: case ($urandom_range(0, 4))
               0: v = 32'h7F800000;
               1: v = 32'hFF800000;
               2: v = 32'h7FC00001;
               3: v = {v[31], 8'h00, v[22:0]};
               default: v = {v[31], 31'b0};
            endcase
         2, 3: begin
            e = int'(other[30:23]) + int'($urandom_range(0, 30)) - 15;
            if (e < 1) e = 1;
            if (e > 254) e = 254;
            v = {v[31], 8'(e), v[22:0]};
         end
         4: v = {~other[31], other[30:3], v[2:0]};
         5: v = {v[31], 8'(253 + $urandom_range(0, 1)), v[22:0]};
         default: v = {v[31], 8'(100 + $urandom_range(0, 54)), v[22:0]};
      endcase
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: no finish within time budget, got timeout required finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] ta, tb_v, want;
      logic        v;

      vecs[0]  = '{32'h3F800000, 32'h40A00000, 32'h40C00000};  // 1 + 5
      vecs[1]  = '{32'h428A0000, 32'h40A00000, 32'h42940000};  // 69 + 5
      vecs[2]  = '{32'h40133333, 32'hC0133333, 32'h00000000};  // cancellation
      vecs[3]  = '{32'h40A00000, 32'hC0133333, 32'h402CCCCD};  // 5 - 2.3
      vecs[4]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000};  // inf - inf
      vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000};  // overflow
      vecs[6]  = '{32'h3F800000, 32'h33800000, 32'h3F800000};  // tie to even, down
      vecs[7]  = '{32'h3F800001, 32'h33800000, 32'h3F800002};  // tie to even, up
      vecs[8]  = '{32'h3F800000, 32'h33800001, 32'h3F800001};  // above half
      vecs[9]  = '{32'h3F800000, 32'hB3000000, 32'h3F800000};  // sub, renorm tie
      vecs[10] = '{32'h7F800001, 32'h3F800000, 32'h7FC00000};  // NaN in
      vecs[11] = '{32'hFF800000, 32'h3F800000, 32'hFF800000};  // inf + finite
      vecs[12] = '{32'h3F800000, 32'h7F800000, 32'h7F800000};  // finite + inf
      vecs[13] = '{32'h80000000, 32'h80000000, 32'h80000000};  // -0 + -0
      vecs[14] = '{32'h00000000, 32'h80000000, 32'h00000000};  // +0 + -0
      vecs[15] = '{32'h80000001, 32'h80000000, 32'h80000000};  // subnormal flush
      vecs[16] = '{32'h00000000, 32'hC0000000, 32'hC0000000};  // zero + x
      vecs[17] = '{32'h00400000, 32'h3F800000, 32'h3F800000};  // subnormal + x
      vecs[18] = '{32'h80800001, 32'h00800000, 32'h80000000};  // underflow flush
      vecs[19] = '{32'h7F7FFFFF, 32'h73000000, 32'h7F800000};  // round to overflow
      vecs[20] = '{32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000};  // negative overflow
      vecs[21] = '{32'h7F800000, 32'h7F800000, 32'h7F800000};  // inf + inf

      // Reset, with in_valid held high to show reset wins.
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.a        = 32'h3F800000;
      bus.b        = 32'h40A00000;
      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", {31'b0, bus.out_valid}, 32'h0);
      chk("reset s", bus.s, 32'h0);
      rst    = 1'b0;
      last_s = 32'h0;

      // Idle after reset: out_valid low, s held at 0.
      step(1'b0, 32'h0, 32'h0, 32'h0, "idle after reset");

      for (int i = 0; i < 22; i++) begin
         step(1'b1, vecs[i].a, vecs[i].b, vecs[i].s, $sformatf("vec%0d", i));
      end

      // Idle cycle holds the last result.
      step(1'b0, 32'h12345678, 32'h9ABCDEF0, last_s, "idle hold");

      // Four back-to-back operations, results in order.
      step(1'b1, 32'h3F800000, 32'h3F800000, 32'h40000000, "b2b0");
      step(1'b1, 32'h40000000, 32'h3F800000, 32'h40400000, "b2b1");
      step(1'b1, 32'h40400000, 32'h3F800000, 32'h40800000, "b2b2");
      step(1'b1, 32'hC0000000, 32'h3F800000, 32'hBF800000, "b2b3");

      // Reset mid-stream with an operation presented on the same edge.
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.a        = 32'h40A00000;
      bus.b        = 32'h40A00000;
      @(posedge clk);
      #1;
      chk("midreset out_valid", {31'b0, bus.out_valid}, 32'h0);
      chk("midreset s", bus.s, 32'h0);
      rst    = 1'b0;
      last_s = 32'h0;
      step(1'b0, 32'h0, 32'h0, 32'h0, "idle after midreset");
      step(1'b1, 32'h40A00000, 32'h40A00000, 32'h41200000, "after midreset");

      // Randomized traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         v    = ($urandom_range(0, 3) != 0);
         ta   = rnd_operand($urandom);
         tb_v = rnd_operand(ta);
         if ($urandom_range(0, 1) == 1) begin
            want = ta;
            ta   = tb_v;
            tb_v = want;
         end
         want = v ? ref_add(ta, tb_v) : last_s;
         step(v, ta, tb_v, want, $sformatf("rand%0d a=%h b=%h", i, ta, tb_v));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
